// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: pipeline port A has priority; host port B
// is forced through after STARVE_LIMIT+1 consecutive lost cycles.
module regfile_wr_arbiter #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ADDR_W       = 3,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              exec,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_stall,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              a_drop
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                a_drop_q, a_drop_d;
  logic                a_acc;
  logic                b_acc;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state; everything freezes while the CPU is halted
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (exec) begin
      case (state_q)
        ST_IDLE: begin
          if (a_valid && b_valid) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (b_acc || !b_valid) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(STARVE_LIMIT)) begin
            state_d = ST_FORCE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_FORCE: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Handshakes and write selection; A and B are mutually exclusive by construction
  always_comb begin
    a_stall   = exec && (state_q == ST_FORCE);
    b_ready   = exec && ((state_q == ST_FORCE) || !a_valid);
    a_acc     = exec && a_valid && !a_stall;
    b_acc     = b_valid && b_ready;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    a_drop_d  = a_drop_q || (a_valid && a_stall);
    if (a_acc) begin
      wr_en_d   = 1'b1;
      wr_addr_d = a_addr;
      wr_data_d = a_data;
    end else if (b_acc) begin
      wr_en_d   = 1'b1;
      wr_addr_d = b_addr;
      wr_data_d = b_data;
    end
  end

  // Registered write port and sticky drop flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      a_drop_q  <= 1'b0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      a_drop_q  <= a_drop_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign a_drop  = a_drop_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized + directed bench for regfile_wr_arbiter against a loss-counting
// reference model and a shadow register file.
module tb_regfile_wr_arbiter;

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 3;
  localparam int unsigned LIM = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          exec, a_valid, b_valid;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          a_stall, b_ready, wr_en, a_drop;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  regfile_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
    .clock(clock), .reset(reset), .exec(exec),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_stall(a_stall),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .a_drop(a_drop)
  );

  always #5 clock = ~clock;

  int unsigned   vec_cnt = 0;
  int unsigned   err_cnt = 0;

  // Reference model: m_lost = consecutive cycles B was requesting and lost to A
  int            m_lost;
  logic          m_wr_en, m_drop;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [DW-1:0] m_rf   [2**AW];
  logic [DW-1:0] dut_rf [2**AW];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lost  = 0;
    m_wr_en = 1'b0;
    m_drop  = 1'b0;
    m_addr  = '0;
    m_data  = '0;
  endtask

  // One clock: drive at posedge+1, check comb outputs at negedge, registered at posedge+1
  task automatic cycle(input logic ex, input logic av, input logic [AW-1:0] aa,
                       input logic [DW-1:0] ad, input logic bv, input logic [AW-1:0] ba,
                       input logic [DW-1:0] bd, output logic took_b);
    logic forced, e_stall, e_bready;
    exec = ex; a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    forced   = (m_lost == int'(LIM) + 1);
    e_stall  = ex && forced;
    e_bready = ex && (forced || !av);
    @(negedge clock);
    check_eq("a_stall", 32'(a_stall), 32'(e_stall));
    check_eq("b_ready", 32'(b_ready), 32'(e_bready));
    @(posedge clock);
    #1;
    took_b  = 1'b0;
    m_wr_en = 1'b0;
    if (ex) begin
      if (av && e_stall) m_drop = 1'b1;
      if (av && !e_stall) begin
        m_wr_en = 1'b1; m_addr = aa; m_data = ad;
      end else if (bv && e_bready) begin
        m_wr_en = 1'b1; m_addr = ba; m_data = bd; took_b = 1'b1;
      end
      if (forced)        m_lost = 0;
      else if (bv && av) m_lost = m_lost + 1;
      else               m_lost = 0;
      if (m_wr_en) m_rf[m_addr] = m_data;
    end
    check_eq("wr_en",   32'(wr_en),   32'(m_wr_en));
    check_eq("wr_addr", 32'(wr_addr), 32'(m_addr));
    check_eq("wr_data", 32'(wr_data), 32'(m_data));
    check_eq("a_drop",  32'(a_drop),  32'(m_drop));
    if (wr_en === 1'b1) dut_rf[wr_addr] = wr_data;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_wr_en"},   32'(wr_en),   32'd0);
    check_eq({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check_eq({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    check_eq({tag, "_a_drop"},  32'(a_drop),  32'd0);
  endtask

  initial begin
    logic          took, bp;
    logic [AW-1:0] bpa;
    logic [DW-1:0] bpd;
    for (int i = 0; i < 2**AW; i++) begin m_rf[i] = '0; dut_rf[i] = '0; end
    model_reset();
    reset = 1'b1; exec = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; a_data = '0; b_addr = '0; b_data = '0;
    #2;
    check_zero_outputs("por");
    #10 reset = 1'b0;
    @(posedge clock);
    #1;

    // A only
    cycle(1'b1, 1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0, took);
    cycle(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, took);

    // A and B together, A idle next: A first, then B
    cycle(1'b1, 1'b1, 3'd1, 16'h00AA, 1'b1, 3'd2, 16'h0055, took);
    cycle(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 16'h0055, took);
    check_eq("ab_b_taken", 32'(took), 32'd1);
    cycle(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, took);

    // A and B held high until B is forced through
    took = 1'b0;
    for (int i = 0; i < 12 && !took; i++)
      cycle(1'b1, 1'b1, 3'($urandom), 16'($urandom), 1'b1, 3'd5, 16'hBEEF, took);
    check_eq("starve_b_taken", 32'(took), 32'd1);
    check_eq("starve_drop", 32'(a_drop), 32'd1);

    // Halt while B is waiting: nothing moves, then arbitration resumes
    cycle(1'b1, 1'b1, 3'd4, 16'h4444, 1'b1, 3'd6, 16'h6666, took);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b1, 3'd4, 16'h4545, 1'b1, 3'd6, 16'h6666, took);
    took = 1'b0;
    for (int i = 0; i < 12 && !took; i++)
      cycle(1'b1, 1'b1, 3'($urandom), 16'($urandom), 1'b1, 3'd6, 16'h6666, took);
    check_eq("halt_b_taken", 32'(took), 32'd1);

    // B withdrawn in WAIT: no B write, loss count restarts
    cycle(1'b1, 1'b1, 3'd1, 16'h1111, 1'b1, 3'd7, 16'h7777, took);
    cycle(1'b1, 1'b1, 3'd1, 16'h1112, 1'b0, 3'd7, 16'h7777, took);
    check_eq("drop_no_b", 32'(wr_data), 32'h1112);
    took = 1'b0;
    for (int i = 0; i < 12 && !took; i++)
      cycle(1'b1, 1'b1, 3'($urandom), 16'($urandom), 1'b1, 3'd7, 16'h7778, took);

    // Reach FORCE, then reset asynchronously mid-cycle
    for (int i = 0; i < int'(LIM) + 1; i++)
      cycle(1'b1, 1'b1, 3'd2, 16'hA5A5, 1'b1, 3'd3, 16'h3C3C, took);
    exec = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    #2;
    check_eq("force_stall", 32'(a_stall), 32'd1);
    reset = 1'b1;
    #1;
    check_zero_outputs("midrst");
    check_eq("midrst_stall", 32'(a_stall), 32'd0);
    model_reset();
    #2 reset = 1'b0;
    @(posedge clock);
    #1;
    cycle(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 16'h3C3C, took);
    check_eq("post_rst_b", 32'(took), 32'd1);

    // Randomized traffic; B requests are held until accepted
    bp = 1'b0; bpa = '0; bpd = '0;
    for (int n = 0; n < 500; n++) begin
      if (!bp && $urandom_range(0, 2) != 0) begin
        bp = 1'b1; bpa = 3'($urandom); bpd = 16'($urandom);
      end
      cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0), 3'($urandom),
            16'($urandom), bp, bpa, bpd, took);
      if (took) bp = 1'b0;
    end

    for (int i = 0; i < 2**AW; i++)
      check_eq($sformatf("rf%0d", i), 32'(dut_rf[i]), 32'(m_rf[i]));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
